// File: rtl/bkram_sector_ctrl.sv
// Backup-RAM sector sequencer between the nvram dpram and the HPS SD sector interface.
// Optional OSD-close autosave of dirty sectors is built when BKRAM_AUTOSAVE_EN is defined.
module bkram_sector_ctrl #(
    parameter int unsigned SECT_W = 6,
    parameter int unsigned LBA_W  = 32
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                bk_ena,
    input  logic                load_req,
    input  logic                save_req,
    input  logic                mount_done,
    input  logic                osd_status,
    input  logic                nvram_we,
    input  logic [SECT_W+8:0]   nvram_a,
    input  logic                sd_ack,
    output logic [LBA_W-1:0]    sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    output logic                busy,
    output logic                loading,
    output logic                dirty
);

    localparam int unsigned NSECT = 1 << SECT_W;

    typedef enum logic [2:0] {IDLE, SEEK, REQ, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic                mode_wr, mode_wr_nxt;
    logic                all_sect, all_sect_nxt;
    logic                acked, acked_nxt;
    logic [SECT_W-1:0]   cursor, cursor_nxt;
    logic [NSECT-1:0]    dirty_map, dirty_map_nxt;
    logic [LBA_W-1:0]    sd_lba_nxt;
    logic                sd_rd_nxt, sd_wr_nxt, busy_nxt, loading_nxt;
    logic                load_q, save_q, ack_q;
    logic                load_lvl, save_lvl, load_rise, save_rise, mount_start, auto_start;
    logic                ack_rise, ack_fall;
    logic                dirty_clr, dirty_wipe;
    logic [SECT_W-1:0]   we_sect;
    logic [8:0]          unused_offs;

    assign load_lvl    = load_req & bk_ena;
    assign save_lvl    = save_req & bk_ena;
    assign load_rise   = load_lvl & ~load_q;
    assign save_rise   = save_lvl & ~save_q;
    assign mount_start = mount_done & bk_ena;
    assign ack_rise    = sd_ack & ~ack_q;
    assign ack_fall    = ~sd_ack & ack_q;
    assign we_sect     = nvram_a[SECT_W+8:9];
    assign unused_offs = nvram_a[8:0];

`ifdef BKRAM_AUTOSAVE_EN
    logic osd_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) osd_q <= 1'b0;
        else       osd_q <= osd_status;
    end

    assign auto_start = osd_status & ~osd_q & bk_ena & (|dirty_map);
`else
    logic unused_osd;

    assign unused_osd = osd_status;
    assign auto_start = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_wr   <= 1'b0;
            all_sect  <= 1'b0;
            acked     <= 1'b0;
            cursor    <= '0;
            dirty_map <= '0;
            sd_lba    <= '0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            busy      <= 1'b0;
            loading   <= 1'b0;
            dirty     <= 1'b0;
            load_q    <= 1'b0;
            save_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_wr   <= mode_wr_nxt;
            all_sect  <= all_sect_nxt;
            acked     <= acked_nxt;
            cursor    <= cursor_nxt;
            dirty_map <= dirty_map_nxt;
            sd_lba    <= sd_lba_nxt;
            sd_rd     <= sd_rd_nxt;
            sd_wr     <= sd_wr_nxt;
            busy      <= busy_nxt;
            loading   <= loading_nxt;
            dirty     <= |dirty_map_nxt;
            load_q    <= load_lvl;
            save_q    <= save_lvl;
            ack_q     <= sd_ack;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt    = state;
        mode_wr_nxt  = mode_wr;
        all_sect_nxt = all_sect;
        acked_nxt    = acked;
        cursor_nxt   = cursor;
        sd_lba_nxt   = sd_lba;
        sd_rd_nxt    = sd_rd;
        sd_wr_nxt    = sd_wr;
        busy_nxt     = busy;
        loading_nxt  = loading;
        dirty_clr    = 1'b0;
        dirty_wipe   = 1'b0;

        case (state)
            IDLE: begin
                if (mount_start || load_rise || save_rise || auto_start) begin
                    cursor_nxt = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = SEEK;
                    if (mount_start || load_rise) begin
                        mode_wr_nxt  = 1'b0;
                        all_sect_nxt = 1'b1;
                        loading_nxt  = 1'b1;
                    end else if (save_rise) begin
                        mode_wr_nxt  = 1'b1;
                        all_sect_nxt = 1'b1;
                    end else begin
                        mode_wr_nxt  = 1'b1;
                        all_sect_nxt = 1'b0;
                    end
                end
            end
            SEEK: begin
                if (all_sect || dirty_map[cursor]) begin
                    state_nxt = REQ;
                end else if (&cursor) begin
                    state_nxt = DONE;
                end else begin
                    cursor_nxt = cursor + SECT_W'(1);
                end
            end
            REQ: begin
                sd_lba_nxt = LBA_W'(cursor);
                sd_rd_nxt  = ~mode_wr;
                sd_wr_nxt  = mode_wr;
                dirty_clr  = mode_wr;
                acked_nxt  = 1'b0;
                state_nxt  = WAIT;
            end
            WAIT: begin
                // Only a fall that follows a rise seen in this WAIT completes the sector
                if (ack_rise) begin
                    sd_rd_nxt = 1'b0;
                    sd_wr_nxt = 1'b0;
                    acked_nxt = 1'b1;
                end else if (acked && ack_fall) begin
                    if (&cursor) begin
                        state_nxt = DONE;
                    end else begin
                        cursor_nxt = cursor + SECT_W'(1);
                        state_nxt  = SEEK;
                    end
                end
            end
            DONE: begin
                busy_nxt    = 1'b0;
                loading_nxt = 1'b0;
                dirty_wipe  = ~mode_wr;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dirty bitmap: CPU writes override a same-cycle clear; ignored during a load
    always_comb begin
        dirty_map_nxt = dirty_map;
        if (dirty_wipe) dirty_map_nxt = '0;
        if (dirty_clr) dirty_map_nxt[cursor] = 1'b0;
        if (nvram_we && !loading) dirty_map_nxt[we_sect] = 1'b1;
    end

endmodule

// File: tb/tb_bkram_sector_ctrl.sv
// Directed self-checking bench for bkram_sector_ctrl with a simple SD handshake responder.
module tb_bkram_sector_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        bk_ena, load_req, save_req, mount_done, osd_status, nvram_we, sd_ack;
    logic [14:0] nvram_a;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, busy, loading, dirty;

    int checks = 0;
    int passes = 0;

    bkram_sector_ctrl dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bk_ena     (bk_ena),
        .load_req   (load_req),
        .save_req   (save_req),
        .mount_done (mount_done),
        .osd_status (osd_status),
        .nvram_we   (nvram_we),
        .nvram_a    (nvram_a),
        .sd_ack     (sd_ack),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .busy       (busy),
        .loading    (loading),
        .dirty      (dirty)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nvram_wr(input logic [14:0] addr);
        nvram_we = 1'b1;
        nvram_a  = addr;
        @(negedge clk_sys);
        nvram_we = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    // Answer every request until busy drops; hook >= 0 writes that sector while its REQ is active
    task automatic serve(input string tag, input logic exp_wr, input int exp_n,
                         input int base, input int hook);
        int n   = 0;
        int bad = 0;
        int cyc = 0;
        while (busy === 1'b1 && cyc < 6000) begin
            if (sd_rd || sd_wr) begin
                if (sd_wr !== exp_wr || sd_rd !== !exp_wr || sd_lba !== 32'(base + n)
                    || loading !== !exp_wr)
                    bad++;
                n++;
                sd_ack = 1'b1;
                @(negedge clk_sys);
                if (sd_rd || sd_wr) bad++;
                sd_ack = 1'b0;
                if (base + n == hook) begin
                    @(negedge clk_sys);
                    @(negedge clk_sys);
                    nvram_wr(15'(hook * 512));
                end
            end
            @(negedge clk_sys);
            cyc++;
        end
        check({tag, "_no_timeout"}, 64'(cyc < 6000), 64'd1);
        check({tag, "_req_count"}, 64'(n), 64'(exp_n));
        check({tag, "_bad_reqs"}, 64'(bad), 64'd0);
        check({tag, "_loading_end"}, 64'(loading), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bk_ena = 1'b0; load_req = 1'b0; save_req = 1'b0; mount_done = 1'b0;
        osd_status = 1'b0; nvram_we = 1'b0; nvram_a = '0; sd_ack = 1'b0;
        wait_cycles(3);
        check("rst_lba", 64'(sd_lba), 64'd0);
        check("rst_rd", 64'(sd_rd), 64'd0);
        check("rst_wr", 64'(sd_wr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_loading", 64'(loading), 64'd0);
        check("rst_dirty", 64'(dirty), 64'd0);
        reset = 1'b0;
        bk_ena = 1'b1;
        @(negedge clk_sys);

        // Mount load wipes a pre-existing dirty mark
        nvram_wr(15'h1400);
        check("pre_mount_dirty", 64'(dirty), 64'd1);
        mount_done = 1'b1;
        @(negedge clk_sys);
        mount_done = 1'b0;
        check("mount_busy", 64'(busy), 64'd1);
        check("mount_loading", 64'(loading), 64'd1);
        serve("mount", 1'b0, 64, 0, -1);
        check("mount_dirty", 64'(dirty), 64'd0);

        // Requests ignored without a mounted image
        bk_ena = 1'b0;
        load_req = 1'b1;
        wait_cycles(4);
        check("noena_busy", 64'(busy), 64'd0);
        check("noena_rd", 64'(sd_rd), 64'd0);
        load_req = 1'b0;
        @(negedge clk_sys);
        bk_ena = 1'b1;
        @(negedge clk_sys);

        // Manual save writes every sector
        nvram_wr(15'h0400);
        nvram_wr(15'h7FFF);
        check("save_pre_dirty", 64'(dirty), 64'd1);
        save_req = 1'b1;
        @(negedge clk_sys);
        check("save_busy", 64'(busy), 64'd1);
        serve("save", 1'b1, 64, 0, -1);
        check("save_dirty", 64'(dirty), 64'd0);
        save_req = 1'b0;
        @(negedge clk_sys);

`ifdef BKRAM_AUTOSAVE_EN
        nvram_wr(15'h0A00);
        nvram_wr(15'h0A01);
        osd_status = 1'b1;
        @(negedge clk_sys);
        check("auto_busy", 64'(busy), 64'd1);
        serve("auto", 1'b1, 1, 5, -1);
        check("auto_dirty", 64'(dirty), 64'd0);
        osd_status = 1'b0;
        @(negedge clk_sys);
`else
        nvram_wr(15'h0A00);
        osd_status = 1'b1;
        wait_cycles(4);
        check("noauto_busy", 64'(busy), 64'd0);
        check("noauto_wr", 64'(sd_wr), 64'd0);
        check("noauto_dirty", 64'(dirty), 64'd1);
        osd_status = 1'b0;
        @(negedge clk_sys);
`endif

        // Simultaneous load+save: load wins, save edges during the load are dropped
        load_req = 1'b1;
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
        @(negedge clk_sys);
        save_req = 1'b1;
        serve("both", 1'b0, 64, 0, -1);
        wait_cycles(6);
        check("both_after_busy", 64'(busy), 64'd0);
        check("both_after_wr", 64'(sd_wr), 64'd0);
        check("both_dirty", 64'(dirty), 64'd0);
        load_req = 1'b0;
        save_req = 1'b0;
        @(negedge clk_sys);

        // CPU write to sector 3 in the same cycle as its write REQ keeps it dirty
        save_req = 1'b1;
        @(negedge clk_sys);
        check("race_busy", 64'(busy), 64'd1);
        serve("race", 1'b1, 64, 0, 3);
        check("race_dirty", 64'(dirty), 64'd1);
        save_req = 1'b0;
        @(negedge clk_sys);

        // Reset in WAIT during a load, then a fresh load from sector 0
        load_req = 1'b1;
        for (int i = 0; i < 20 && sd_rd !== 1'b1; i++) @(negedge clk_sys);
        check("mid_rd_seen", 64'(sd_rd), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_rd", 64'(sd_rd), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_loading", 64'(loading), 64'd0);
        check("mid_rst_dirty", 64'(dirty), 64'd0);
        load_req = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        wait_cycles(2);
        check("post_rst_idle", 64'(busy), 64'd0);
        load_req = 1'b1;
        @(negedge clk_sys);
        check("reload_busy", 64'(busy), 64'd1);
        serve("reload", 1'b0, 64, 0, -1);
        check("reload_dirty", 64'(dirty), 64'd0);
        load_req = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
